// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC to a combinational instruction ROM and
// fills the IF/ID register, with redirect handling and a sticky fault state.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'hBFC00000,
    parameter int unsigned ROM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] ROM_BYTES_W  = 32'(ROM_BYTES);
    localparam logic [31:0] NOP_INSTR    = 32'h00000013;
    localparam logic [1:0]  CAUSE_ALIGN  = 2'b01;
    localparam logic [1:0]  CAUSE_WINDOW = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] pc_offset_s;
    logic        in_window_s;
    logic        capture_s;
    logic        clr_valid_s;
    logic [1:0]  cause_next_s;
    logic [31:0] fault_pc_next_s;
    logic        if_valid_r;
    logic [31:0] if_instr_r;
    logic [31:0] if_pc_r;
    logic [31:0] if_pc_plus4_r;
    logic [1:0]  fault_cause_r;
    logic [31:0] fault_pc_r;
    logic [31:0] fetch_count_r;

    // Offset is modulo 2^32, so addresses below the base wrap to large values and fail the check.
    assign pc_offset_s = pc_r - RESET_PC;
    assign in_window_s = (pc_offset_s < ROM_BYTES_W);
    assign pc_plus4_s  = pc_r + 32'd4;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: misaligned redirects and out-of-window PCs are terminal until reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (redirect_en) begin
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_next_s = ST_FAULT;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else if (!in_window_s) begin
                    state_next_s = ST_FAULT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FAULT: state_next_s = ST_FAULT;
            default:  state_next_s = ST_RUN;
        endcase
    end

    // Per-state datapath controls; redirect outranks stall, the window check does not care about stall.
    always_comb begin
        pc_next_s       = pc_r;
        capture_s       = 1'b0;
        clr_valid_s     = 1'b0;
        cause_next_s    = fault_cause_r;
        fault_pc_next_s = fault_pc_r;
        case (state_r)
            ST_RUN: begin
                if (redirect_en) begin
                    clr_valid_s = 1'b1;
                    if (redirect_pc[1:0] == 2'b00) begin
                        pc_next_s = redirect_pc;
                    end else begin
                        cause_next_s    = CAUSE_ALIGN;
                        fault_pc_next_s = redirect_pc;
                    end
                end else if (!in_window_s) begin
                    clr_valid_s     = 1'b1;
                    cause_next_s    = CAUSE_WINDOW;
                    fault_pc_next_s = pc_r;
                end else if (!stall) begin
                    capture_s = 1'b1;
                    pc_next_s = pc_plus4_s;
                end else begin
                    capture_s = 1'b0;
                end
            end
            ST_FAULT: clr_valid_s = 1'b1;
            default:  clr_valid_s = 1'b1;
        endcase
    end

    // PC, IF/ID register, fault record and accepted-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            if_valid_r    <= 1'b0;
            if_instr_r    <= NOP_INSTR;
            if_pc_r       <= 32'h00000000;
            if_pc_plus4_r <= 32'h00000000;
            fault_cause_r <= 2'b00;
            fault_pc_r    <= 32'h00000000;
            fetch_count_r <= 32'h00000000;
        end else begin
            pc_r          <= pc_next_s;
            fault_cause_r <= cause_next_s;
            fault_pc_r    <= fault_pc_next_s;
            if (clr_valid_s) begin
                if_valid_r <= 1'b0;
            end else if (capture_s) begin
                if_valid_r    <= 1'b1;
                if_instr_r    <= imem_rd;
                if_pc_r       <= pc_r;
                if_pc_plus4_r <= pc_plus4_s;
            end
            // Decode consumes the IF/ID content whenever it is valid and not stalled.
            if (if_valid_r && !stall) begin
                fetch_count_r <= fetch_count_r + 32'd1;
            end
        end
    end

    assign imem_addr   = pc_r;
    assign if_valid    = if_valid_r;
    assign if_instr    = if_instr_r;
    assign if_pc       = if_pc_r;
    assign if_pc_plus4 = if_pc_plus4_r;
    assign fault       = (state_r == ST_FAULT);
    assign fault_cause = fault_cause_r;
    assign fault_pc    = fault_pc_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus pushes expected accepted instructions into a
// queue; a negedge monitor pops and compares on every decode accept.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .stall      (stall),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_pc_plus4(if_pc_plus4),
        .fault      (fault),
        .fault_cause(fault_cause),
        .fault_pc   (fault_pc),
        .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM content: word at address A is C0DE0 followed by A[11:0]; outside the window reads DEADBEEF.
    assign imem_rd = ((imem_addr - 32'hBFC00000) < 32'd4096) ?
                     {16'hC0DE, 4'h0, imem_addr[11:0]} : 32'hDEADBEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        exp_q.push_back(e);
    endtask

    // Monitor: every decode accept must match the next expected instruction.
    always @(negedge clk) begin
        if (!rst && if_valid === 1'b1 && stall === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_accept: got instr %h pc %h expected none", if_instr, if_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("acc_instr", if_instr, e.instr);
                chk("acc_pc", if_pc, e.pc);
                chk("acc_pc4", if_pc_plus4, e.pc4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h00000000;
        step();
        step();
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'h00000013);
        chk("rst_pc", if_pc, 32'h00000000);
        chk("rst_pc4", if_pc_plus4, 32'h00000000);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_cause", {30'd0, fault_cause}, 32'd0);
        chk("rst_fpc", fault_pc, 32'h00000000);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_addr", imem_addr, 32'hBFC00000);

        // Sequential fetch W0..W4 from the reset PC.
        push(32'hC0DE0000, 32'hBFC00000);
        push(32'hC0DE0004, 32'hBFC00004);
        push(32'hC0DE0008, 32'hBFC00008);
        push(32'hC0DE000C, 32'hBFC0000C);
        push(32'hC0DE0010, 32'hBFC00010);
        rst = 1'b0;
        step();
        chk("first_valid", {31'd0, if_valid}, 32'd1);
        chk("first_pc", if_pc, 32'hBFC00000);
        chk("first_addr", imem_addr, 32'hBFC00004);
        step();
        step();
        step();
        chk("w3_instr", if_instr, 32'hC0DE000C);
        chk("w3_count", fetch_count, 32'd3);
        step();
        chk("count_after4", fetch_count, 32'd4);
        chk("w4_instr", if_instr, 32'hC0DE0010);

        // Stall for three cycles: everything holds.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_instr", if_instr, 32'hC0DE0010);
            chk("stall_pc", if_pc, 32'hBFC00010);
            chk("stall_addr", imem_addr, 32'hBFC00014);
            chk("stall_count", fetch_count, 32'd4);
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
        end
        stall = 1'b0;
        step();
        chk("post_stall_count", fetch_count, 32'd5);
        chk("post_stall_instr", if_instr, 32'hC0DE0014);

        // Redirect with stall in the same cycle: redirect wins, stalled W5 is dropped.
        redirect_en = 1'b1;
        redirect_pc = 32'hBFC00100;
        stall       = 1'b1;
        step();
        chk("redir_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'hBFC00100);
        chk("redir_count", fetch_count, 32'd5);
        redirect_en = 1'b0;
        stall       = 1'b0;
        push(32'hC0DE0100, 32'hBFC00100);
        step();
        chk("redir_target", if_instr, 32'hC0DE0100);
        chk("redir_target_pc", if_pc, 32'hBFC00100);

        // Misaligned redirect faults; PC stays at the next sequential address.
        redirect_en = 1'b1;
        redirect_pc = 32'hBFC00102;
        step();
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_cause", {30'd0, fault_cause}, 32'd1);
        chk("mis_fpc", fault_pc, 32'hBFC00102);
        chk("mis_valid", {31'd0, if_valid}, 32'd0);
        chk("mis_addr", imem_addr, 32'hBFC00104);
        chk("mis_count", fetch_count, 32'd6);
        redirect_pc = 32'hBFC00200;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("flt_fault", {31'd0, fault}, 32'd1);
            chk("flt_addr", imem_addr, 32'hBFC00104);
            chk("flt_valid", {31'd0, if_valid}, 32'd0);
            chk("flt_cause", {30'd0, fault_cause}, 32'd1);
            chk("flt_fpc", fault_pc, 32'hBFC00102);
        end

        // Reset overrides fault, stall and redirect.
        rst   = 1'b1;
        stall = 1'b1;
        step();
        chk("rf_fault", {31'd0, fault}, 32'd0);
        chk("rf_cause", {30'd0, fault_cause}, 32'd0);
        chk("rf_addr", imem_addr, 32'hBFC00000);
        chk("rf_count", fetch_count, 32'd0);
        chk("rf_instr", if_instr, 32'h00000013);
        chk("rf_valid", {31'd0, if_valid}, 32'd0);

        // Jump near the top of the window and run off its end.
        rst         = 1'b0;
        stall       = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 32'hBFC00FF8;
        step();
        chk("top_addr", imem_addr, 32'hBFC00FF8);
        redirect_en = 1'b0;
        push(32'hC0DE0FF8, 32'hBFC00FF8);
        push(32'hC0DE0FFC, 32'hBFC00FFC);
        step();
        step();
        chk("last_instr", if_instr, 32'hC0DE0FFC);
        chk("last_pc4", if_pc_plus4, 32'hBFC01000);
        chk("last_fault", {31'd0, fault}, 32'd0);
        step();
        chk("off_fault", {31'd0, fault}, 32'd1);
        chk("off_cause", {30'd0, fault_cause}, 32'd2);
        chk("off_fpc", fault_pc, 32'hBFC01000);
        chk("off_valid", {31'd0, if_valid}, 32'd0);
        chk("off_count", fetch_count, 32'd2);
        stall = 1'b1;
        step();
        chk("off_hold_fault", {31'd0, fault}, 32'd1);
        chk("off_hold_addr", imem_addr, 32'hBFC01000);
        chk("off_hold_fpc", fault_pc, 32'hBFC01000);

        rst   = 1'b1;
        stall = 1'b0;
        step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'hBFC00000, meaning the boot PC and base of the instruction ROM window.
REQ-002 The module SHALL have parameter ROM_BYTES, default 4096, meaning the ROM window size in bytes; the window is [RESET_PC, RESET_PC+ROM_BYTES-1].
REQ-003 The module SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, meaning reset; it is synchronous and active-high.
REQ-005 The module SHALL have port imem_addr, output, 32, meaning the byte address to instruction memory.
REQ-006 The module SHALL have port imem_rd, input, 32, meaning the little-endian instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 The module SHALL have port stall, input, 1, meaning decode cannot accept; hold outputs.
REQ-008 The module SHALL have port redirect_en, input, 1, meaning a branch/jump redirect this cycle.
REQ-009 The module SHALL have port redirect_pc, input, 32, meaning the redirect target byte address.
REQ-010 The module SHALL have port if_valid, output, 1, meaning the IF/ID register holds a valid instruction.
REQ-011 The module SHALL have ports if_instr, if_pc, if_pc_plus4, outputs, 32 each, meaning the registered instruction, its PC, and PC+4.
REQ-012 The module SHALL have port fault, output, 1, meaning a sticky fetch fault.
REQ-013 The module SHALL have port fault_cause, output, 2, meaning 2'b01 = misaligned redirect and 2'b10 = PC outside ROM window.
REQ-014 The module SHALL have port fault_pc, output, 32, meaning the offending address.
REQ-015 The module SHALL have port fetch_count, output, 32, meaning the number of instructions accepted by decode.

Function
REQ-016 imem_addr SHALL equal the internal PC register combinationally at all times.
REQ-017 The FSM SHALL have two states: RUN and FAULT.
REQ-018 In RUN, with redirect_en=0, stall=0, and PC in window:
- IF/ID captures imem_rd, PC, and PC+4.
- if_valid <= 1.
- PC <= PC+4 (32-bit modulo).
REQ-019 In RUN, with stall=1 and redirect_en=0, PC, if_valid, if_instr, if_pc, and if_pc_plus4 SHALL hold unchanged.
REQ-020 Redirect in RUN, with redirect_pc[1:0]==0, SHALL take priority over stall:
- PC <= redirect_pc.
- if_valid <= 0 (one bubble).
- The current imem_rd is discarded.
REQ-021 Redirect in RUN with redirect_pc[1:0]!=0 SHALL:
- Enter FAULT with fault_cause=01 and fault_pc=redirect_pc.
- Set if_valid <= 0 and leave PC unchanged.
REQ-022 In RUN with no redirect, if PC is outside the window, the unit SHALL:
- Enter FAULT with fault_cause=10 and fault_pc=PC.
- Set if_valid <= 0 and perform no capture.
- Apply this regardless of stall.
REQ-023 Sequential fall-off is a fault: fetch at RESET_PC+ROM_BYTES-4 completes normally; the next cycle faults with cause 10.
REQ-024 In FAULT, the unit SHALL:
- Hold PC.
- Keep if_valid=0.
- Ignore redirect_en and stall.
- Keep fault=1 and fault_cause/fault_pc stable until rst.
REQ-025 fault SHALL be 1 exactly when the state is FAULT.
REQ-026 fetch_count SHALL increment by 1 on every cycle with if_valid=1 and stall=0, and SHALL wrap 32'hFFFFFFFF -> 0.
REQ-027 Fetch latency SHALL be one cycle: an instruction at PC appears on if_instr the cycle after PC is driven on imem_addr.
REQ-028 After a redirect, the target instruction SHALL appear on if_instr exactly two cycles after the redirect cycle.

Reset
REQ-029 When rst=1 at a rising edge, the unit SHALL set:
- PC=RESET_PC, state=RUN.
- if_valid=0, if_instr=32'h00000013 (NOP).
- if_pc=0, if_pc_plus4=0.
- fault=0, fault_cause=0, fault_pc=0.
- fetch_count=0.
REQ-030 rst SHALL override every other input, including during stall, during redirect, and while in FAULT.
REQ-031 The first fetch after reset SHALL read RESET_PC; if_valid first rises one cycle after rst deasserts.

Verification
REQ-032 Reset release with ROM words W0..W3 at 0xBFC00000.. and stall=0 -> if_instr=W0,W1,W2,W3 on consecutive cycles; if_pc=0xBFC00000,..04,..08,..0C; fetch_count=4 after the 4th accept.
REQ-033 stall=1 for 3 cycles while if_instr=W1 -> W1 and if_pc=0xBFC00004 held 3 cycles; imem_addr held at 0xBFC00008; fetch_count unchanged during stall.
REQ-034 redirect_en=1, redirect_pc=0xBFC00100 with stall=1 asserted in the same cycle -> next cycle if_valid=0 and imem_addr=0xBFC00100; the cycle after, if_instr=ROM[0xBFC00100].
REQ-035 redirect_pc=0xBFC00102 -> fault=1, fault_cause=01, fault_pc=0xBFC00102; if_valid stays 0; a later valid redirect is ignored.
REQ-036 Sequential run to 0xBFC00FFC -> that word is delivered; next cycle fault=1, fault_cause=10, fault_pc=0xBFC01000.
REQ-037 rst=1 while in FAULT -> next cycle fault=0, imem_addr=0xBFC00000, fetch_count=0, if_instr=0x00000013.
